// File: rtl/dht_disp_pkg.sv
// rtl/dht_disp_pkg.sv - shared states, segment codes and TM1638 byte map for the DHT display formatter
package dht_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        ENCODE,
        DONE
    } state_t;

    // Segment byte order, MSB first: a b c d e f g dp
    localparam logic [7:0] SEG_0     = 8'b1111_1100;
    localparam logic [7:0] SEG_1     = 8'b0110_0000;
    localparam logic [7:0] SEG_2     = 8'b1101_1010;
    localparam logic [7:0] SEG_3     = 8'b1111_0010;
    localparam logic [7:0] SEG_4     = 8'b0110_0110;
    localparam logic [7:0] SEG_5     = 8'b1011_0110;
    localparam logic [7:0] SEG_6     = 8'b1011_1110;
    localparam logic [7:0] SEG_7     = 8'b1110_0000;
    localparam logic [7:0] SEG_8     = 8'b1111_1110;
    localparam logic [7:0] SEG_9     = 8'b1111_0110;
    localparam logic [7:0] SEG_H     = 8'b0110_1110;
    localparam logic [7:0] SEG_C     = 8'b1001_1100;
    localparam logic [7:0] SEG_DEG   = 8'b1100_0110;
    localparam logic [7:0] SEG_DASH  = 8'b0000_0010;
    localparam logic [7:0] SEG_E     = 8'b1001_1110;
    localparam logic [7:0] SEG_R     = 8'b0000_1010;
    localparam logic [7:0] SEG_BLANK = 8'b0000_0000;

    localparam logic [7:0] LED_ON  = 8'b1000_0000;
    localparam logic [7:0] LED_OFF = 8'b0000_0000;

    localparam int ADDR_HUM_TENS  = 0;
    localparam int ADDR_HUM_UNITS = 2;
    localparam int ADDR_HUM_SYM   = 4;
    localparam int ADDR_GAP       = 6;
    localparam int ADDR_TMP_TENS  = 8;
    localparam int ADDR_TMP_UNITS = 10;
    localparam int ADDR_TMP_DEG   = 12;
    localparam int ADDR_TMP_SYM   = 14;
    localparam int ADDR_LED_ERR   = 1;
    localparam int ADDR_LED_HB    = 15;

    function automatic logic [7:0] seg_digit(input logic [3:0] d);
        logic [7:0] code;
        case (d)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - iterative 8-bit double-dabble, one shift-add-3 step per cycle
module bin2bcd_seq #(
    parameter int CONV_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic [11:0] bcd,
    output logic        done
);

    localparam logic [2:0] LAST_ITER = 3'(CONV_CYCLES - 1);

    // {hundreds, tens, units, binary} shifted left as one word
    logic [19:0] r_sh;
    logic [2:0]  r_cnt;
    logic        r_busy;
    logic [19:0] w_adj;

    always_comb begin
        w_adj = r_sh;
        for (int i = 0; i < 3; i++) begin
            if (r_sh[8 + 4*i +: 4] >= 4'd5) begin
                w_adj[8 + 4*i +: 4] = r_sh[8 + 4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh   <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_sh   <= {12'd0, bin};
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_sh  <= {w_adj[18:0], 1'b0};
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == LAST_ITER) begin
                r_busy <= 1'b0;
            end
        end
    end

    // High while the final iteration is being applied on the coming edge
    assign done = r_busy && (r_cnt == LAST_ITER);
    assign bcd  = r_sh[19:8];

endmodule

// File: rtl/dht_display_formatter.sv
// rtl/dht_display_formatter.sv - DHT11 reading to TM1638 16-byte segment/LED image
// Optional leading-zero blanking of tens digits: define DHT_FMT_LZB_EN.
module dht_display_formatter
    import dht_disp_pkg::*;
#(
    parameter int CONV_CYCLES = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   hum_int,
    input  logic [7:0]   temp_int,
    input  logic         chk_ok,
    output logic [127:0] seg_buf,
    output logic         buf_valid
);

    state_t         r_state;
    state_t         w_next;
    logic           r_chk;
    logic           r_hb;
    logic           r_buf_valid;
    logic [127:0]   r_seg_buf;
    logic [127:0]   w_img;
    logic [7:0]     w_bytes [16];
    logic           w_accept;
    logic [11:0]    w_hum_bcd;
    logic [11:0]    w_tmp_bcd;
    logic           w_hum_done;
    logic           w_tmp_done;
    logic [15:0]    w_hum_pair;
    logic [15:0]    w_tmp_pair;

    assign in_ready = (r_state == IDLE) && !rst;
    assign w_accept = in_valid && in_ready;

    bin2bcd_seq #(.CONV_CYCLES(CONV_CYCLES)) u_hum_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (w_accept),
        .bin   (hum_int),
        .bcd   (w_hum_bcd),
        .done  (w_hum_done)
    );

    bin2bcd_seq #(.CONV_CYCLES(CONV_CYCLES)) u_tmp_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (w_accept),
        .bin   (temp_int),
        .bcd   (w_tmp_bcd),
        .done  (w_tmp_done)
    );

    // Two display digits {tens, units}; anything above 99 shows as dashes
    function automatic logic [15:0] enc_pair(input logic [11:0] bcd);
        logic [7:0] tens;
        if (bcd[11:8] != 4'd0) begin
            return {SEG_DASH, SEG_DASH};
        end
        tens = seg_digit(bcd[7:4]);
`ifdef DHT_FMT_LZB_EN
        if (bcd[7:4] == 4'd0) begin
            tens = SEG_BLANK;
        end
`endif
        return {tens, seg_digit(bcd[3:0])};
    endfunction

    assign w_hum_pair = enc_pair(w_hum_bcd);
    assign w_tmp_pair = enc_pair(w_tmp_bcd);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = CONV;
            CONV:    if (w_hum_done && w_tmp_done) w_next = ENCODE;
            ENCODE:  w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        for (int k = 0; k < 16; k++) begin
            w_bytes[k] = SEG_BLANK;
        end
        if (r_chk) begin
            w_bytes[ADDR_HUM_TENS]  = w_hum_pair[15:8];
            w_bytes[ADDR_HUM_UNITS] = w_hum_pair[7:0];
            w_bytes[ADDR_HUM_SYM]   = SEG_H;
            w_bytes[ADDR_GAP]       = SEG_BLANK;
            w_bytes[ADDR_TMP_TENS]  = w_tmp_pair[15:8];
            w_bytes[ADDR_TMP_UNITS] = w_tmp_pair[7:0];
            w_bytes[ADDR_TMP_DEG]   = SEG_DEG;
            w_bytes[ADDR_TMP_SYM]   = SEG_C;
        end else begin
            w_bytes[0] = SEG_E;
            w_bytes[2] = SEG_R;
            w_bytes[4] = SEG_R;
        end
        w_bytes[ADDR_LED_ERR] = r_chk ? LED_OFF : LED_ON;
        w_bytes[ADDR_LED_HB]  = r_hb  ? LED_ON  : LED_OFF;

        w_img = '0;
        for (int k = 0; k < 16; k++) begin
            w_img[127 - 8*k -: 8] = w_bytes[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_chk       <= 1'b0;
            r_hb        <= 1'b0;
            r_seg_buf   <= '0;
            r_buf_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_buf_valid <= (r_state == DONE);
            if (w_accept) begin
                r_chk <= chk_ok;
                r_hb  <= ~r_hb;
            end
            if (r_state == ENCODE) begin
                r_seg_buf <= w_img;
            end
        end
    end

    assign seg_buf   = r_seg_buf;
    assign buf_valid = r_buf_valid;

endmodule

// File: tb/tb_dht_display_formatter.sv
// tb/tb_dht_display_formatter.sv - directed self-checking bench for dht_display_formatter
module tb_dht_display_formatter;

    localparam logic [7:0] S0 = 8'b1111_1100, S1 = 8'b0110_0000, S2 = 8'b1101_1010;
    localparam logic [7:0] S3 = 8'b1111_0010, S4 = 8'b0110_0110, S5 = 8'b1011_0110;
    localparam logic [7:0] S6 = 8'b1011_1110, S7 = 8'b1110_0000, S9 = 8'b1111_0110;
    localparam logic [7:0] SH = 8'b0110_1110, SC = 8'b1001_1100, SDEG = 8'b1100_0110;
    localparam logic [7:0] SDASH = 8'b0000_0010, SE = 8'b1001_1110, SR = 8'b0000_1010;
    localparam logic [7:0] BL = 8'h00, ON = 8'h80, OFF = 8'h00;
`ifdef DHT_FMT_LZB_EN
    localparam logic [7:0] ZT = BL;
`else
    localparam logic [7:0] ZT = S0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   hum;
    logic [7:0]   temp;
    logic         chk_ok;
    logic [127:0] seg_buf;
    logic         buf_valid;

    int   n_pass  = 0;
    int   n_total = 0;
    logic exp_hb  = 1'b0;

    always #5 clk = ~clk;

    dht_display_formatter #(.CONV_CYCLES(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .hum_int   (hum),
        .temp_int  (temp),
        .chk_ok    (chk_ok),
        .seg_buf   (seg_buf),
        .buf_valid (buf_valid)
    );

    // Present one reading, wait for its accept edge, return edges until buf_valid (-1 on timeout)
    task automatic run_reading(input logic [7:0] h, input logic [7:0] t, input logic c,
                               output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        hum = h; temp = t; chk_ok = c; in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_hb   = ~exp_hb;
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (buf_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; hum = '0; temp = '0; chk_ok = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++;
        if (seg_buf !== 128'h0) $display("FAIL reset_seg_buf: got %h want 0", seg_buf); else n_pass++;
        n_total++;
        if (buf_valid !== 1'b0) $display("FAIL reset_buf_valid: got %b want 0", buf_valid); else n_pass++;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else n_pass++;
        rst = 1'b0;
        exp_hb = 1'b0;
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL idle_in_ready: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_basic();
        int lat;
        logic [127:0] exp;
        run_reading(8'd45, 8'd23, 1'b1, lat);
        n_total++;
        if (lat !== 10) $display("FAIL basic_latency: got %0d want 10", lat); else n_pass++;
        exp = {S4, OFF, S5, OFF, SH, OFF, BL, OFF, S2, OFF, S3, OFF, SDEG, OFF, SC, (exp_hb ? ON : OFF)};
        for (int k = 0; k < 16; k++) begin
            n_total++;
            if (seg_buf[127-8*k -: 8] !== exp[127-8*k -: 8])
                $display("FAIL basic_byte%0d: got %b want %b", k, seg_buf[127-8*k -: 8], exp[127-8*k -: 8]);
            else n_pass++;
        end
    endtask

    task automatic test_small_values();
        int lat;
        logic [127:0] exp;
        run_reading(8'd7, 8'd0, 1'b1, lat);
        n_total++;
        if (lat !== 10) $display("FAIL small_latency: got %0d want 10", lat); else n_pass++;
        exp = {ZT, OFF, S7, OFF, SH, OFF, BL, OFF, ZT, OFF, S0, OFF, SDEG, OFF, SC, (exp_hb ? ON : OFF)};
        for (int k = 0; k < 16; k++) begin
            n_total++;
            if (seg_buf[127-8*k -: 8] !== exp[127-8*k -: 8])
                $display("FAIL small_byte%0d: got %b want %b", k, seg_buf[127-8*k -: 8], exp[127-8*k -: 8]);
            else n_pass++;
        end
    endtask

    task automatic test_range();
        int lat;
        logic [127:0] exp;
        run_reading(8'd150, 8'd99, 1'b1, lat);
        n_total++;
        if (lat !== 10) $display("FAIL range_latency: got %0d want 10", lat); else n_pass++;
        exp = {SDASH, OFF, SDASH, OFF, SH, OFF, BL, OFF, S9, OFF, S9, OFF, SDEG, OFF, SC, (exp_hb ? ON : OFF)};
        for (int k = 0; k < 16; k++) begin
            n_total++;
            if (seg_buf[127-8*k -: 8] !== exp[127-8*k -: 8])
                $display("FAIL range_byte%0d: got %b want %b", k, seg_buf[127-8*k -: 8], exp[127-8*k -: 8]);
            else n_pass++;
        end
    endtask

    task automatic test_chk_error();
        int lat;
        logic [127:0] exp;
        run_reading(8'd45, 8'd23, 1'b0, lat);
        n_total++;
        if (lat !== 10) $display("FAIL chkerr_latency: got %0d want 10", lat); else n_pass++;
        exp = {SE, ON, SR, OFF, SR, OFF, BL, OFF, BL, OFF, BL, OFF, BL, OFF, BL, (exp_hb ? ON : OFF)};
        for (int k = 0; k < 16; k++) begin
            n_total++;
            if (seg_buf[127-8*k -: 8] !== exp[127-8*k -: 8])
                $display("FAIL chkerr_byte%0d: got %b want %b", k, seg_buf[127-8*k -: 8], exp[127-8*k -: 8]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int   acc [$];
        int   ready_cnt;
        int   lat;
        logic ready_s;
        ready_cnt = 0;
        @(negedge clk);
        hum = 8'd12; temp = 8'd34; chk_ok = 1'b1; in_valid = 1'b1;
        for (int cyc = 0; cyc < 46; cyc++) begin
            if (cyc != 0) @(negedge clk);
            ready_s = in_ready;
            if (ready_s) ready_cnt++;
            if (buf_valid) begin
                n_total++;
                if (seg_buf[7:0] !== (exp_hb ? ON : OFF))
                    $display("FAIL b2b_heartbeat_cyc%0d: got %b want %b", cyc, seg_buf[7:0], (exp_hb ? ON : OFF));
                else n_pass++;
            end
            @(posedge clk);
            if (ready_s) begin
                acc.push_back(cyc);
                exp_hb = ~exp_hb;
            end
        end
        #1;
        in_valid = 1'b0;
        n_total++;
        if (acc.size() !== 5) $display("FAIL b2b_accept_count: got %0d want 5", acc.size()); else n_pass++;
        n_total++;
        if (ready_cnt !== 5) $display("FAIL b2b_ready_cycles: got %0d want 5", ready_cnt); else n_pass++;
        for (int i = 1; i < acc.size(); i++) begin
            n_total++;
            if (acc[i] - acc[i-1] !== 11)
                $display("FAIL b2b_spacing%0d: got %0d want 11", i, acc[i] - acc[i-1]);
            else n_pass++;
        end
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (buf_valid) begin
                lat = k;
                break;
            end
        end
        n_total++;
        if (lat < 0) $display("FAIL b2b_drain: got timeout want buf_valid"); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [127:0] exp;
        @(negedge clk);
        hum = 8'd88; temp = 8'd11; chk_ok = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if (seg_buf !== 128'h0) $display("FAIL midrst_seg_buf: got %h want 0", seg_buf); else n_pass++;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL midrst_in_ready: got %b want 0", in_ready); else n_pass++;
        rst = 1'b0;
        exp_hb = 1'b0;
        hum = 8'd61; temp = 8'd5; chk_ok = 1'b1; in_valid = 1'b1;
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL midrst_ready_after: got %b want 1", in_ready); else n_pass++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_hb = ~exp_hb;
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (buf_valid) begin
                lat = k;
                break;
            end
        end
        n_total++;
        if (lat !== 10) $display("FAIL midrst_latency: got %0d want 10", lat); else n_pass++;
        exp = {S6, OFF, S1, OFF, SH, OFF, BL, OFF, ZT, OFF, S5, OFF, SDEG, OFF, SC, (exp_hb ? ON : OFF)};
        for (int k = 0; k < 16; k++) begin
            n_total++;
            if (seg_buf[127-8*k -: 8] !== exp[127-8*k -: 8])
                $display("FAIL midrst_byte%0d: got %b want %b", k, seg_buf[127-8*k -: 8], exp[127-8*k -: 8]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_small_values();
        test_range();
        test_chk_error();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dht_display_formatter.md
# dht_display_formatter

Converts one validated DHT11 reading (integer humidity, integer temperature, checksum status) into the 128-bit segment/LED image that the TM1638 front-panel driver shifts out during its 16-byte auto-increment data phase. It sits between the DHT11 sensor reader and the TM1638 driver. It runs a sequential binary-to-BCD conversion and 7-segment encoding, then publishes a complete buffer with a one-cycle strobe.

## Interface
- `CONV_CYCLES`, default 8: number of double-dabble iterations; fixed to the 8-bit input width.
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: a reading is presented.
- `in_ready` output 1: block is idle and accepts a reading this cycle.
- `hum_int` input 8: humidity integer part, binary.
- `temp_int` input 8: temperature integer part, binary.
- `chk_ok` input 1: DHT11 checksum matched.
- `seg_buf` output 128: display image. Byte k is `seg_buf[127-8k -: 8]`; it is transmitted as TM1638 address k.
- `buf_valid` output 1: one-cycle strobe marking that `seg_buf` has been updated.

## Operation
- Accept: a reading is accepted on a rising edge with `in_valid && in_ready`. The block registers `hum_int`, `temp_int` and `chk_ok`.
- `in_ready = (state == IDLE) && !rst`.
- States:
  - IDLE → CONV on accept.
  - CONV: 8 iterations of shift-add-3, both bytes in parallel, with a 3-bit iteration counter → ENCODE when the counter reaches 7.
  - ENCODE: `seg_buf` written in one cycle → DONE.
  - DONE: `buf_valid` = 1 → IDLE.
- Segment byte bit order, MSB first: a, b, c, d, e, f, g, dp.
- Digit codes:
  - Digits: 0=11111100, 1=01100000, 2=11011010, 3=11110010, 4=01100110, 5=10110110, 6=10111110, 7=11100000, 8=11111110, 9=11110110.
  - Symbols: H=01101110, C=10011100, degree=11000110, dash=00000010, E=10011110, r=00001010, blank=00000000.
- Layout with `chk_ok=1`:
  - Even bytes 0..14 = hum tens, hum units, H, blank, temp tens, temp units, degree, C.
- Range: a value whose BCD hundreds digit ≠ 0 (input > 99) shows dash, dash in both of its digits.
- Layout with `chk_ok=0`:
  - Bytes 0, 2, 4 = E, r, r.
  - Bytes 6..14 = blank.
  - Conversion still runs, so latency is unchanged.
- LED bytes (odd addresses): ON = 10000000, OFF = 00000000.
  - Byte 1 = ON iff `!chk_ok`.
  - Byte 15 = heartbeat: toggles on every accepted reading.
  - All other odd bytes = OFF.
- Between updates, `seg_buf` holds its last value. The TM1638 driver may sample it at any time; it changes only in the ENCODE cycle.

## Timing
- Reset values:
  - `seg_buf` = 128'h0 (all blank, LEDs off).
  - `buf_valid` = 0.
  - `in_ready` = 0 while `rst` is high.
  - State = IDLE, heartbeat = 0.
- Latency: accept at edge N; CONV occupies N+1..N+8; ENCODE updates `seg_buf` at edge N+9; `buf_valid` is high during the cycle after edge N+10.
- Throughput: one reading per 11 cycles. `in_valid` asserted while busy is ignored; there is no queueing, and the upstream block must hold or drop.
- Reset mid-operation: returns to IDLE within one cycle, clears `seg_buf`, and suppresses any pending `buf_valid`.
- Accept and DONE coincide: impossible, because `in_ready` is 0 in DONE. The next accept is possible in the IDLE cycle after DONE.

## Configuration
- `DHT_FMT_LZB_EN` defined: leading-zero blanking. A tens digit of 0 is shown blank (5 → blank, 5); units are always shown.
- `DHT_FMT_LZB_EN` undefined: the tens digit is always shown (5 → 0, 5).

## Structure
- Package `dht_disp_pkg` holds:
  - the state enum (IDLE, CONV, ENCODE, DONE);
  - all 8-bit segment constants;
  - the LED ON/OFF constants;
  - the byte-address localparams for the layout.
- Sub-module `bin2bcd_seq`: iterative 8-bit double-dabble with `start`/`done` and a 12-bit BCD output. It is instantiated twice (humidity, temperature), driven by the same start. The top module owns the FSM, encoding and buffer assembly.

## Test plan
- hum=45, temp=23, chk_ok=1 → bytes 0..14 even = 01100110, 10110110, 01101110, 0, 11011010, 11110010, 11000110, 10011100; byte1=0; byte15=ON; `buf_valid` exactly 10 cycles after accept.
- hum=7, temp=0, chk_ok=1 → byte0 = blank with `DHT_FMT_LZB_EN`, 11111100 without; byte2=11100000; byte10=11111100.
- hum=150, temp=99, chk_ok=1 → bytes 0, 2 = dash; bytes 8, 10 = 11110110.
- chk_ok=0 → bytes 0, 2, 4 = E, r, r; byte1=ON; remaining even bytes blank.
- `in_valid` held high continuously → accepts exactly every 11 cycles; byte15 toggles each time; `in_ready` low during CONV/ENCODE/DONE.
- `rst` pulsed at CONV iteration 4 → no `buf_valid`; `seg_buf`=0; next reading accepted the first cycle after `rst` falls and completes normally.
